decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage feeding the ALU. Accepts a 32-bit RV32I instruction from fetch over a valid/ready handshake and reads the integer register file, which has a bypassed writeback port. It produces a registered operand bundle for the ALU: `func3`, `func7`, `rs1_data`, `rs2_data`, plus destination and branch metadata for the downstream execute/writeback logic. It holds a one-entry output register with stall and flush.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and operand width
- `REG_COUNT`, 32, architectural registers; x0 reads as zero

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: fetch presents an instruction
- `in_ready` out 1: stage can accept this cycle
- `in_instr` in 32: instruction word
- `in_pc` in DATA_WIDTH: instruction address
- `wb_we` in 1: register write enable
- `wb_rd` in 5: write address
- `wb_data` in DATA_WIDTH: write data
- `flush` in 1: discard held and incoming instruction
- `out_valid` out 1: ALU bundle valid
- `out_ready` in 1: downstream consumes bundle
- `func3` out 3, `func7` out 7: ALU operation code
- `rs1_data` out DATA_WIDTH, `rs2_data` out DATA_WIDTH: ALU operands
- `rd` out 5, `rd_we` out 1: destination and write enable; `rd_we` = 0 for branches and illegal ops
- `is_branch` out 1: bundle is a conditional branch; ALU compare result selects taken
- `branch_target` out DATA_WIDTH: `in_pc` + sign-extended B-immediate
- `illegal` out 1: unsupported opcode or encoding

## Operation
- **OP (0110011):**
  - `func3` and `func7` are taken from the instruction.
  - `func7` values other than 0000000 and 0100000 → `illegal`.
  - 0100000 is legal only with `func3` 000 or 101.
- **OP-IMM (0010011):**
  - `rs2_data` = sign-extended I-immediate.
  - `func7` = 0, except for `func3` 001 and 101.
  - For `func3` 001 and 101: `rs2_data` = zero-extended shamt `instr[24:20]`, and `func7` = `instr[31:25]`. This must be 0000000, or 0100000 only with `func3` 101; otherwise `illegal`.
- **BRANCH (1100011):** `rs2_data` = rs2 register and `rd_we` = 0. The ALU code `{func7,func3}` is:
  - BEQ → 1000000_100
  - BNE → 1000000_110
  - BLT → 1000000_001 (signed)
  - BLTU → 1000000_111 (unsigned)
  - BGE → 1100000_101 (signed)
  - BGEU → 1000000_101 (unsigned)
  - `func3` 010 and 011 → `illegal`.
- **Any other opcode:** `illegal` = 1, ALU code ADD (all zero), operands passed, `rd_we` = 0.
- **Register reads:**
  - Reads are combinational at accept.
  - If `wb_we` && `wb_rd` == source && source != 0, `wb_data` is used (same-cycle bypass).
  - x0 always reads 0, and writes to x0 are ignored.

## Timing
- `in_ready` = `!out_valid || out_ready`, combinational.
- **Accept:** on an edge where `in_valid && in_ready && !flush`, the bundle is registered and `out_valid` = 1 the next cycle. Latency is 1 cycle.
- **Stall:** while `out_valid && !out_ready`, all outputs hold stable and `in_ready` = 0.
- **Back-to-back:** `out_valid && out_ready && in_valid` in the same cycle replaces the bundle with no bubble.
- **Drain:** `out_ready` with no new accept clears `out_valid`.
- **Flush:** wins over everything. `out_valid` clears at the next edge and an instruction presented in the same cycle is dropped. Register-file writes still occur during flush.
- **Writeback timing:** a register-file write lands at the edge. A write coinciding with a stall does not alter the already-captured operands.
- **Reset** (asynchronous, any time, including mid-stall):
  - `out_valid`, `rd_we`, `is_branch` and `illegal` go to 0.
  - All bundle fields go to 0.
  - All registers are cleared to 0.
  - `in_ready` = 1 once reset has dropped.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - the ALU operation codes (10-bit `{func7,func3}`), including the branch compare codes above
  - immediate-extraction functions (I, B)
- Sub-module `reg_file`:
  - REG_COUNT × DATA_WIDTH storage
  - two combinational read ports with write bypass
  - one write port
  - asynchronous reset to zero
- `decode_stage` holds the decode logic and the output register.

## Test plan
- Reset mid-stall:
  - Stimulus: hold `out_ready` = 0 with a valid bundle, pulse `rst`.
  - Response: `out_valid` = 0 immediately, `rs1_data` = 0, and reading any register afterwards returns 0.
- ADDI with bypass:
  - Stimulus: write x1 = 5 via wb, then 0xFFF08113 (`addi x2,x1,-1`).
  - Response: one cycle later `func3`/`func7` = 0, `rs1_data` = 5, `rs2_data` = 0xFFFFFFFF, `rd` = 2, `rd_we` = 1.
  - Repeat with the wb write to x1 in the same cycle as the accept: `rs1_data` must equal the bypassed value.
- SRAI and illegal shift:
  - Stimulus: 0x4030D093 (`srai x1,x1,3`), then the same encoding with `instr[31:25]` = 0000001.
  - Response: first gives `func7` = 0100000, `func3` = 101, `rs2_data` = 3; second gives `illegal` = 1, `rd_we` = 0.
- Branch mapping:
  - Stimulus: BLT x1,x2,+16 at pc 0x100.
  - Response: `{func7,func3}` = 1000000_001, `is_branch` = 1, `rd_we` = 0, `branch_target` = 0x110.
  - Repeat for all six branch conditions, checking each code.
- Stall and back-to-back:
  - Stimulus: stream 3 instructions with `out_ready` low for 2 cycles mid-stream.
  - Response: outputs stable while stalled, `in_ready` = 0, no loss or duplication, then one bundle per cycle.
- Flush:
  - Stimulus: assert `flush` with a held bundle and a new `in_valid`.
  - Response: next cycle `out_valid` = 0 and neither instruction emerges.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I opcodes, ALU {func7,func3} operation codes, decode control bundle
// and immediate helpers shared by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // func7[6] marks a compare; the ALU result bit selects branch taken.
  localparam logic [9:0] ALU_ADD  = 10'b0000000_000;
  localparam logic [9:0] ALU_BEQ  = 10'b1000000_100;
  localparam logic [9:0] ALU_BNE  = 10'b1000000_110;
  localparam logic [9:0] ALU_BLT  = 10'b1000000_001;
  localparam logic [9:0] ALU_BLTU = 10'b1000000_111;
  localparam logic [9:0] ALU_BGE  = 10'b1100000_101;
  localparam logic [9:0] ALU_BGEU = 10'b1000000_101;

  typedef struct packed {
    logic [6:0] func7;
    logic [2:0] func3;
    logic [4:0] rd;
    logic       rd_we;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  function automatic logic [11:0] imm_i(input logic [31:0] instr);
    return instr[31:20];
  endfunction

  function automatic logic [12:0] imm_b(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file, x0 hardwired to zero, two read ports, one write port.
// Latency: reads combinational with same-cycle write bypass; write lands at the edge.
// Backpressure: none; always accepts reads and writes.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write in flight wins over the stored value so decode sees it this cycle.
  assign rs1_data = (rs1_addr == 5'd0)                 ? '0      :
                    (wr_en && wr_addr == rs1_addr)     ? wr_data : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0)                 ? '0      :
                    (wr_en && wr_addr == rs2_addr)     ? wr_data : regs[rs2_addr];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode into a registered ALU operand bundle with branch metadata.
// Latency: 1 cycle from accept to out_valid; back-to-back with no bubble.
// Backpressure: in_ready = !out_valid || out_ready; bundle holds while stalled.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [4:0]            rd,
  output logic                  rd_we,
  output logic                  is_branch,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic                  illegal
);

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic [6:0]            f7;
  logic [DATA_WIDTH-1:0] rf_rs1, rf_rs2;
  logic [11:0]           imm_i_raw;
  logic [12:0]           imm_b_raw;
  logic [DATA_WIDTH-1:0] imm_i_ext, imm_b_ext, shamt_ext;
  logic [9:0]            alu_d;
  ctrl_t                 ctrl_d, ctrl_q;
  logic [DATA_WIDTH-1:0] op2_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs2_q, tgt_q;
  logic                  valid_q;
  logic                  accept;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (in_instr[19:15]),
    .rs2_addr (in_instr[24:20]),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .wr_en    (wb_we),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  assign imm_i_raw = imm_i(in_instr);
  assign imm_b_raw = imm_b(in_instr);
  assign imm_i_ext = {{(DATA_WIDTH-12){imm_i_raw[11]}}, imm_i_raw};
  assign imm_b_ext = {{(DATA_WIDTH-13){imm_b_raw[12]}}, imm_b_raw};
  assign shamt_ext = {{(DATA_WIDTH-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    ctrl_d    = '0;
    ctrl_d.rd = in_instr[11:7];
    alu_d     = ALU_ADD;
    op2_d     = rf_rs2;
    case (opcode)
      OPC_OP: begin
        alu_d          = {f7, f3};
        ctrl_d.illegal = !((f7 == F7_BASE) ||
                           (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
        ctrl_d.rd_we   = !ctrl_d.illegal;
      end
      OPC_OP_IMM: begin
        if (f3 == F3_SLL || f3 == F3_SR) begin
          alu_d          = {f7, f3};
          op2_d          = shamt_ext;
          ctrl_d.illegal = !((f7 == F7_BASE) || (f7 == F7_ALT && f3 == F3_SR));
        end else begin
          alu_d = {F7_BASE, f3};
          op2_d = imm_i_ext;
        end
        ctrl_d.rd_we = !ctrl_d.illegal;
      end
      OPC_BRANCH: begin
        ctrl_d.is_branch = 1'b1;
        case (f3)
          BR_BEQ:  alu_d = ALU_BEQ;
          BR_BNE:  alu_d = ALU_BNE;
          BR_BLT:  alu_d = ALU_BLT;
          BR_BGE:  alu_d = ALU_BGE;
          BR_BLTU: alu_d = ALU_BLTU;
          BR_BGEU: alu_d = ALU_BGEU;
          default: begin
            ctrl_d.is_branch = 1'b0;
            ctrl_d.illegal   = 1'b1;
          end
        endcase
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    {ctrl_d.func7, ctrl_d.func3} = alu_d;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Fields only load on accept, so a stalled bundle cannot see later writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tgt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rf_rs1;
      rs2_q   <= op2_d;
      tgt_q   <= in_pc + imm_b_ext;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign func3         = ctrl_q.func3;
  assign func7         = ctrl_q.func7;
  assign rd            = ctrl_q.rd;
  assign rd_we         = ctrl_q.rd_we;
  assign is_branch     = ctrl_q.is_branch;
  assign illegal       = ctrl_q.illegal;
  assign rs1_data      = rs1_q;
  assign rs2_data      = rs2_q;
  assign branch_target = tgt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: per-cycle compare against a spec-level
// model, plus literal expectations for the hand-decoded vectors.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        rd_we;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .func3         (func3),
    .func7         (func7),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd            (rd),
    .rd_we         (rd_we),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  logic [31:0] mregs [32];
  logic        exp_valid;
  exp_t        exp_b;

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         boff;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    e     = '0;
    e.rd  = ins[11:7];
    e.a   = rdreg(ins[19:15]);
    e.b   = rdreg(ins[24:20]);
    boff  = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    e.tgt = pc + boff;
    if (opc == 7'h33) begin
      e.f7  = f7;
      e.f3  = f3;
      e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      e.we  = !e.ill;
    end else if (opc == 7'h13) begin
      e.f3 = f3;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.f7  = f7;
        e.b   = {27'd0, ins[24:20]};
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
      end else begin
        e.b = $signed(ins[31:20]);
      end
      e.we = !e.ill;
    end else if (opc == 7'h63) begin
      e.br = 1'b1;
      case (f3)
        3'd0: {e.f7, e.f3} = 10'b1000000_100;   // BEQ
        3'd1: {e.f7, e.f3} = 10'b1000000_110;   // BNE
        3'd4: {e.f7, e.f3} = 10'b1000000_001;   // BLT
        3'd5: {e.f7, e.f3} = 10'b1100000_101;   // BGE
        3'd6: {e.f7, e.f3} = 10'b1000000_111;   // BLTU
        3'd7: {e.f7, e.f3} = 10'b1000000_101;   // BGEU
        default: begin e.br = 1'b0; e.ill = 1'b1; end
      endcase
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_b     <= '0;
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
    end else begin
      if (flush) exp_valid <= 1'b0;
      else if (in_valid && (!exp_valid || out_ready)) begin
        exp_valid <= 1'b1;
        exp_b     <= model(in_instr, in_pc);
      end else if (out_ready) exp_valid <= 1'b0;
      if (wb_we && wb_rd != 5'd0) mregs[wb_rd] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_out_valid", out_valid, exp_valid);
      chk("m_in_ready", in_ready, !exp_valid || out_ready);
      if (exp_valid) begin
        chk("m_func", {func7, func3}, {exp_b.f7, exp_b.f3});
        chk("m_rs1", rs1_data, exp_b.a);
        chk("m_rs2", rs2_data, exp_b.b);
        chk("m_rd", {rd, rd_we}, {exp_b.rd, exp_b.we});
        chk("m_branch", {is_branch, illegal}, {exp_b.br, exp_b.ill});
        chk("m_target", branch_target, exp_b.tgt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    wb_we    = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    cyc();
    wb_we = 1'b0;
  endtask

  logic [2:0]  bf3   [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [9:0]  bcode [6] = '{10'h204, 10'h206, 10'h201, 10'h305, 10'h207, 10'h205};
  logic [31:0] strm  [3] = '{32'h00100293, 32'h00200313, 32'h00300393};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  got [$];
    logic [31:0] snap_rs2;
    logic [9:0]  snap_f;
    logic [4:0]  snap_rd;
    int          idx;
    logic        acc;

    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flags", {rd_we, is_branch, illegal}, 3'b000);
    chk("rst_rs1", rs1_data, 32'd0);
    chk("rst_target", branch_target, 32'd0);

    wb(5'd1, 32'd5);
    wb(5'd2, 32'hA5A50003);
    wb(5'd0, 32'hDEAD);

    send(32'hFFF08113, 32'h0);                // addi x2,x1,-1
    chk("addi_func", {func7, func3}, 10'd0);
    chk("addi_rs1", rs1_data, 32'd5);
    chk("addi_rs2", rs2_data, 32'hFFFFFFFF);
    chk("addi_rd", {rd, rd_we}, {5'd2, 1'b1});

    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    send(32'hFFF08113, 32'h4);
    chk("bypass_rs1", rs1_data, 32'h1234);

    send(32'h4030D093, 32'h8);                // srai x1,x1,3
    chk("srai_func", {func7, func3}, {7'b0100000, 3'b101});
    chk("srai_rs2", rs2_data, 32'd3);
    send(32'h0230D093, 32'hC);
    chk("badshift", {illegal, rd_we}, 2'b10);

    for (int i = 0; i < 6; i++) begin
      send(32'h00208863 | (32'(bf3[i]) << 12), 32'h100);
      chk("br_code", {func7, func3}, bcode[i]);
      chk("br_flags", {is_branch, rd_we, illegal}, 3'b100);
      chk("br_target", branch_target, 32'h110);
    end
    send(32'h0020A863, 32'h100);              // branch funct3 010
    chk("br_illegal", {illegal, rd_we}, 2'b10);
    send(32'hFE208EE3, 32'h100);              // beq x1,x2,-4
    chk("br_back_target", branch_target, 32'h0FC);

    send(32'h402081B3, 32'h10);               // sub x3,x1,x2
    chk("sub_func", {func7, func3, illegal}, {7'h20, 3'd0, 1'b0});
    send(32'h402091B3, 32'h14);
    send(32'h022081B3, 32'h18);
    send(32'h002081B3, 32'h1C);
    send(32'h123450B7, 32'h20);               // lui: unsupported
    chk("lui", {illegal, rd_we, func7, func3}, {1'b1, 1'b0, 10'd0});
    cyc();

    // Stream three instructions with a two-cycle stall after the first handoff.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx >= 3 && !out_valid) break;
      out_ready = !(c == 2 || c == 3);
      in_valid  = (idx < 3);
      if (idx < 3) in_instr = strm[idx];
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got.push_back(rd);
      if (c == 2) begin
        chk("stall_in_ready", in_ready, 1'b0);
        snap_rs2 = rs2_data; snap_f = {func7, func3}; snap_rd = rd;
      end
      if (c == 3) chk("stall_hold", {rs2_data, snap_f, rd}, {snap_rs2, {func7, func3}, snap_rd});
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_done", idx, 3);
    chk("stream_cnt", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("stream_rd", (i < got.size()) ? got[i] : 5'h1F, 5'(5 + i));

    cyc();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h30);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300393;
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h77;
    cyc();
    flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk("flush_drop", out_valid, 1'b0);
    send(32'h00048533, 32'h34);               // add x10,x9,x0
    chk("flush_wb", rs1_data, 32'h77);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'hFFF08113, 32'h40);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_rs1", rs1_data, 32'd0);
    chk("rst_stall_flags", {rd_we, is_branch, illegal}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_stall_ready", in_ready, 1'b1);
    send(32'h00208533, 32'h44);               // add x10,x1,x2
    chk("rst_regs", {rs1_data, rs2_data}, 64'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
